// File: rtl/fir_decim_pkg.sv
// Shared types and coefficients for the decimate-by-2 half-band FIR stage.
package fir_decim_pkg;

  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 15;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Half-band Q1.15 taps: every second tap away from the centre is zero, DC gain is exactly 1.0.
  localparam coef_t HALFBAND_COEFS [15] = '{
    -16'sd158, 16'sd0, 16'sd770,   16'sd0, -16'sd2470, 16'sd0, 16'sd10050,
     16'sd16384,
     16'sd10050, 16'sd0, -16'sd2470, 16'sd0, 16'sd770,  16'sd0, -16'sd158
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

endpackage

// File: rtl/fir_decim_mac.sv
// Signed multiply-accumulate used by the FIR stage: one product per enabled cycle.
module fir_decim_mac
  import fir_decim_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 36
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      enable_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  coef_t                     coef_i,
  output logic signed [ACC_W-1:0]   acc_o
);

  localparam int PROD_W = SAMPLE_W + COEF_W;

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  acc_q;

  assign product     = sample_i * coef_i;
  assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (enable_i) begin
      acc_q <= acc_q + product_ext;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_decim_stage.sv
// Decimate-by-2 half-band FIR stage: tap line, phase counter, MAC sequencer and output saturation.
// Define FIR_DECIM_ROUND_EN to round half up before the Q1.15 shift instead of truncating.
module fir_decim_stage
  import fir_decim_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_TAPS   = 15,
  parameter int DECIMATION = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] audio_in,
  input  logic                    audio_sample_valid,
  output logic signed [WIDTH-1:0] dec_output,
  output logic                    dec_output_ready
);

  localparam int ACC_W = WIDTH + COEF_W + $clog2(NUM_TAPS);
  localparam int K_W   = $clog2(NUM_TAPS);
  localparam int PH_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] taps_q [NUM_TAPS];
  logic signed [WIDTH-1:0] taps_d [NUM_TAPS];
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    pend_valid_q, pend_valid_d;
  logic signed [WIDTH-1:0] pend_sample_q, pend_sample_d;
  logic                    overflow_q, overflow_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    ready_q, ready_d;

  logic                    mac_clear, mac_en, shift_en;
  logic signed [WIDTH-1:0] shift_sample;
  logic signed [WIDTH-1:0] cur_tap;
  coef_t                   cur_coef;
  logic signed [ACC_W-1:0] acc, rounded, shifted;
  logic signed [WIDTH-1:0] sat_value;

  assign cur_tap  = taps_q[k_q];
  assign cur_coef = HALFBAND_COEFS[k_q];

  fir_decim_mac #(
    .SAMPLE_W(WIDTH),
    .ACC_W   (ACC_W)
  ) u_mac (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .clear_i (mac_clear),
    .enable_i(mac_en),
    .sample_i(cur_tap),
    .coef_i  (cur_coef),
    .acc_o   (acc)
  );

`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (COEF_FRAC-1);
  assign rounded = acc + ROUND_HALF;
`else
  assign rounded = acc;
`endif

  assign shifted   = rounded >>> COEF_FRAC;
  assign sat_value = (shifted > SAT_MAX) ? SAT_MAX[WIDTH-1:0] :
                     (shifted < SAT_MIN) ? SAT_MIN[WIDTH-1:0] : shifted[WIDTH-1:0];

  // Valids that arrive while busy park in a single pending slot; a second one is lost and flagged.
  always_comb begin
    state_d       = state_q;
    taps_d        = taps_q;
    phase_d       = phase_q;
    k_d           = k_q;
    pend_valid_d  = pend_valid_q;
    pend_sample_d = pend_sample_q;
    overflow_d    = overflow_q;
    out_d         = out_q;
    ready_d       = 1'b0;
    mac_clear     = 1'b0;
    mac_en        = 1'b0;
    shift_en      = 1'b0;
    shift_sample  = audio_in;

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          shift_en     = 1'b1;
          shift_sample = pend_sample_q;
          pend_valid_d = 1'b0;
          if (audio_sample_valid) begin
            pend_valid_d  = 1'b1;
            pend_sample_d = audio_in;
          end
        end else if (audio_sample_valid) begin
          shift_en = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + K_W'(1);
        if (k_q == K_W'(NUM_TAPS-1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_d   = sat_value;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && audio_sample_valid) begin
      if (pend_valid_q) begin
        overflow_d = 1'b1;
      end else begin
        pend_valid_d  = 1'b1;
        pend_sample_d = audio_in;
      end
    end

    // The sample completing a decimation period kicks off the filter evaluation.
    if (shift_en) begin
      taps_d[0] = shift_sample;
      for (int i = 1; i < NUM_TAPS; i++) begin
        taps_d[i] = taps_q[i-1];
      end
      if (phase_q == PH_W'(DECIMATION-1)) begin
        phase_d   = '0;
        state_d   = MAC;
        k_d       = '0;
        mac_clear = 1'b1;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      taps_q        <= '{default: '0};
      phase_q       <= '0;
      k_q           <= '0;
      pend_valid_q  <= 1'b0;
      pend_sample_q <= '0;
      overflow_q    <= 1'b0;
      out_q         <= '0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      taps_q        <= taps_d;
      phase_q       <= phase_d;
      k_q           <= k_d;
      pend_valid_q  <= pend_valid_d;
      pend_sample_q <= pend_sample_d;
      overflow_q    <= overflow_d;
      out_q         <= out_d;
      ready_q       <= ready_d;
    end
  end

  assign dec_output       = out_q;
  assign dec_output_ready = ready_q;

endmodule

// File: tb/tb_fir_decim_stage.sv
// Directed self-checking bench for fir_decim_stage: reset, latency, impulse, DC, saturation, pending path.
module tb_fir_decim_stage;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic signed [15:0] audio_in = '0;
  logic               audio_sample_valid = 1'b0;
  logic signed [15:0] dec_output;
  logic               dec_output_ready;

  int testCount = 0;
  int failCount = 0;
  int readyCount = 0;
  int cyc = 0;
  int validCycle = 0;
  int lastReadyCycle = 0;
  logic signed [15:0] outQ [$];

  int impA [8] = '{0, 0, 0, 8192, 0, 0, 0, 0};
  int impB [9] = '{-79, 385, -1235, 5025, 5025, -1235, 385, -79, 0};

  fir_decim_stage dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .audio_in          (audio_in),
    .audio_sample_valid(audio_sample_valid),
    .dec_output        (dec_output),
    .dec_output_ready  (dec_output_ready)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Capture every ready pulse away from the active edge.
  always @(negedge clk_in) begin
    if (dec_output_ready === 1'b1) begin
      outQ.push_back(dec_output);
      readyCount++;
      lastReadyCycle = cyc;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [15:0] value);
    @(posedge clk_in);
    #1;
    audio_in = value;
    audio_sample_valid = 1'b1;
    validCycle = cyc;
    @(posedge clk_in);
    #1;
    audio_sample_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic signed [31:0] getOut(input int idx);
    logic signed [31:0] v;
    v = 'x;
    if (idx < outQ.size()) v = outQ[idx];
    return v;
  endfunction

  task automatic doReset();
    rst_in = 1'b0;
    audio_sample_valid = 1'b0;
    waitCycles(3);
    rst_in = 1'b1;
    outQ.delete();
    readyCount = 0;
  endtask

  initial begin
    // Reset held with random valid traffic: nothing may come out.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      #1;
      audio_in = 16'($urandom);
      audio_sample_valid = 1'($urandom_range(0, 1));
    end
    audio_sample_valid = 1'b0;
    waitCycles(2);
    checkOutput("resetNoReady", readyCount, 0);
    checkOutput("resetOutput", dec_output, 0);

    // First output only after the second sample, 17 cycles after its valid.
    rst_in = 1'b1;
    outQ.delete();
    readyCount = 0;
    applyStimulus(16'sd0);
    waitCycles(30);
    checkOutput("firstSampleNoReady", readyCount, 0);
    applyStimulus(16'sd0);
    for (int i = 0; i < 40 && readyCount == 0; i++) waitCycles(1);
    checkOutput("latency", lastReadyCycle - validCycle, 17);
    checkOutput("zeroOutput", getOut(0), 0);

    // Impulse as first sample: odd-index taps appear, centre gives 8192.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i == 0 ? 16'sd16384 : 16'sd0);
      waitCycles(24);
    end
    checkOutput("impulseA_count", readyCount, 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("impulseA_%0d", i), getOut(i), impA[i]);

    // Impulse as second sample: even-index taps h[k]/2 then zero.
    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(i == 1 ? 16'sd16384 : 16'sd0);
      waitCycles(24);
    end
    checkOutput("impulseB_count", readyCount, 9);
    for (int i = 0; i < 9; i++) checkOutput($sformatf("impulseB_%0d", i), getOut(i), impB[i]);

    // DC 1000 every 32 cycles: unity gain once the tap line is full.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'sd1000);
      waitCycles(30);
    end
    checkOutput("dc_count", readyCount, 10);
    for (int i = 7; i < 10; i++) checkOutput($sformatf("dc_%0d", i), getOut(i), 1000);

    // Positive and negative full scale: overshoot after 14 samples must clamp.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'sd32767);
      waitCycles(24);
    end
    checkOutput("satPosOvershoot", getOut(6), 32767);
    checkOutput("satPosSteady", getOut(7), 32767);
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(-16'sd32768);
      waitCycles(24);
    end
    checkOutput("satNegOvershoot", getOut(6), -32768);
    checkOutput("satNegSteady", getOut(7), -32768);

    // Two consecutive valids during MAC: first goes pending, second is dropped.
    doReset();
    applyStimulus(16'sd0);
    waitCycles(24);
    applyStimulus(16'sd1000);
    waitCycles(2);
    audio_in = 16'sd2000;
    audio_sample_valid = 1'b1;
    waitCycles(1);
    audio_in = 16'sd3000;
    waitCycles(1);
    audio_sample_valid = 1'b0;
    waitCycles(30);
    checkOutput("b2b_noExtraReady", readyCount, 1);
    checkOutput("b2b_overflowFlag", dut.overflow_q, 1);
    applyStimulus(16'sd0);
    waitCycles(24);
    checkOutput("b2b_readyAfterNext", readyCount, 2);
    checkOutput("b2b_output", getOut(1), 23);

    // Reset in the middle of a MAC aborts it and restarts the decimation phase.
    doReset();
    checkOutput("overflowCleared", dut.overflow_q, 0);
    applyStimulus(16'sd500);
    waitCycles(24);
    applyStimulus(16'sd500);
    waitCycles(5);
    rst_in = 1'b0;
    waitCycles(2);
    rst_in = 1'b1;
    waitCycles(30);
    checkOutput("abort_noReady", readyCount, 0);
    checkOutput("abort_output", dec_output, 0);
    applyStimulus(16'sd0);
    waitCycles(30);
    checkOutput("abort_oneSampleNoReady", readyCount, 0);
    applyStimulus(16'sd0);
    waitCycles(24);
    checkOutput("abort_twoSamplesReady", readyCount, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
